cuppa_trig_ctrl: RTL and testbench

Trigger sequencer for the CUPPA digitizer channel. Unpacks the 18-bit cuppa trig bundle, runs threshold-crossing detection on the ADC sample stream and edge detection on the external trigger, and issues one trigger request per event to the capture engine over a req/ack handshake. Enforces holdoff and run gating, and keeps an event counter for status readback.

---
 rtl/cuppa_trig_ctrl.sv | 156 +++++++++++++++
 tb/tb_cuppa_trig_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/cuppa_trig_ctrl.sv
// cuppa_trig_ctrl: trigger sequencer for one CUPPA digitizer channel.
// It detects threshold crossings on the ADC stream and rising edges on
// the external trigger. It issues one req/ack request per event, then
// waits out a holdoff period and keeps a count of accepted triggers.
module cuppa_trig_ctrl #(
  parameter int HOLDOFF_CYC = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [17:0]      trig_bundle,
  input  logic [11:0]      adc_data,
  input  logic             adc_valid,
  input  logic             ext_trig,
  output logic             trig_req,
  input  logic             trig_ack,
  output logic [1:0]       trig_src,
  output logic [CNT_W-1:0] trig_cnt,
  output logic             armed,
  output logic [2:0]       state_o
);

  // Last holdoff count value. A holdoff of zero still spends one cycle in HOLDOFF.
  localparam int HC_LAST = (HOLDOFF_CYC > 0) ? HOLDOFF_CYC - 1 : 0;
  localparam int HW      = (HC_LAST > 0) ? $clog2(HC_LAST + 1) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    REQ     = 3'd2,
    HOLDOFF = 3'd3
  } state_t;

  state_t state, state_next;

  logic        trig_et, trig_gt, trig_lt, trig_run;
  logic [11:0] trig_thresh;
  logic        thresh_trig_en, ext_trig_en;

  logic [11:0] prev_sample;
  logic        prev_valid;
  logic        ext_prev;
  logic [HW-1:0] hold_cnt;
  logic        hold_done;

  logic        thresh_hit, ext_hit, any_hit;
  logic        enter_armed, accept, latch_src;

  assign trig_et        = trig_bundle[0];
  assign trig_gt        = trig_bundle[1];
  assign trig_lt        = trig_bundle[2];
  assign trig_run       = trig_bundle[3];
  assign trig_thresh    = trig_bundle[15:4];
  assign thresh_trig_en = trig_bundle[16];
  assign ext_trig_en    = trig_bundle[17];

  assign hold_done = (hold_cnt == HW'(HC_LAST));

  // Hit detection. Threshold modes need a valid previous sample so that
  // a stale value from before arming can never produce a false crossing.
  always_comb begin
    thresh_hit = 1'b0;
    if (adc_valid && thresh_trig_en && prev_valid) begin
      thresh_hit = (trig_et && (adc_data == trig_thresh)) ||
                   (trig_gt && (prev_sample <= trig_thresh) && (adc_data > trig_thresh)) ||
                   (trig_lt && (prev_sample >= trig_thresh) && (adc_data < trig_thresh));
    end
    ext_hit = ext_trig_en && ext_trig && !ext_prev;
    any_hit = thresh_hit || ext_hit;
  end

  // Next-state and outputs. Dropping run while ARMED wins over any hit.
  // A request that has already been raised stays up until it is acknowledged.
  always_comb begin
    state_next  = state;
    enter_armed = 1'b0;
    accept      = 1'b0;
    latch_src   = 1'b0;
    trig_req    = 1'b0;
    armed       = 1'b0;
    state_o     = state;
    case (state)
      IDLE: begin
        if (trig_run) begin
          state_next  = ARMED;
          enter_armed = 1'b1;
        end
      end
      ARMED: begin
        armed = 1'b1;
        if (!trig_run) begin
          state_next = IDLE;
        end else if (any_hit) begin
          state_next = REQ;
          latch_src  = 1'b1;
        end
      end
      REQ: begin
        trig_req = 1'b1;
        if (trig_ack) begin
          state_next = HOLDOFF;
          accept     = 1'b1;
        end
      end
      HOLDOFF: begin
        if (hold_done) begin
          state_next = trig_run ? ARMED : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath: sample history, edge history, holdoff timer, source latch and event counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_sample <= '0;
      prev_valid  <= 1'b0;
      ext_prev    <= 1'b0;
      hold_cnt    <= '0;
      trig_src    <= 2'b00;
      trig_cnt    <= '0;
    end else begin
      ext_prev <= ext_trig;
      if (adc_valid) begin
        prev_sample <= adc_data;
      end
      if (enter_armed) begin
        prev_valid <= 1'b0;
      end else if (adc_valid) begin
        prev_valid <= 1'b1;
      end
      if (state == HOLDOFF) begin
        hold_cnt <= hold_cnt + HW'(1);
      end else begin
        hold_cnt <= '0;
      end
      if (latch_src) begin
        trig_src <= {ext_hit, thresh_hit};
      end
      if (accept) begin
        trig_cnt <= trig_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cuppa_trig_ctrl.sv
// tb_cuppa_trig_ctrl: directed and random stimulus for cuppa_trig_ctrl.
// Every cycle is compared against an event-level reference model.
module tb_cuppa_trig_ctrl;

  localparam int CNT_W   = 4;
  localparam int HOLDOFF = 16;
  localparam int CNT_MOD = 1 << CNT_W;

  logic             clk = 1'b0;
  logic             rst;
  logic [17:0]      trig_bundle;
  logic [11:0]      adc_data;
  logic             adc_valid;
  logic             ext_trig;
  logic             trig_req;
  logic             trig_ack;
  logic [1:0]       trig_src;
  logic [CNT_W-1:0] trig_cnt;
  logic             armed;
  logic [2:0]       state_o;

  logic        b_et, b_gt, b_lt, b_run, b_ten, b_een;
  logic [11:0] b_thresh;

  int checks = 0;
  int errors = 0;

  // Reference model state: mode (0 idle, 1 armed, 2 req, 3 holdoff) and bookkeeping.
  int m_mode, m_src, m_cnt, m_prev, m_remaining;
  bit m_prev_ok, m_ext_prev;

  assign trig_bundle = {b_een, b_ten, b_thresh, b_run, b_lt, b_gt, b_et};

  cuppa_trig_ctrl #(.HOLDOFF_CYC(HOLDOFF), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .trig_bundle(trig_bundle), .adc_data(adc_data),
    .adc_valid(adc_valid), .ext_trig(ext_trig), .trig_req(trig_req),
    .trig_ack(trig_ack), .trig_src(trig_src), .trig_cnt(trig_cnt),
    .armed(armed), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  // Advances the model by one clock edge, using the inputs currently driven.
  task automatic modelStep();
    int  d, th;
    bit  th_hit, ex_hit;
    d  = int'(adc_data);
    th = int'(b_thresh);
    if (rst) begin
      m_mode = 0; m_src = 0; m_cnt = 0; m_prev = 0;
      m_prev_ok = 0; m_ext_prev = 0; m_remaining = 0;
      return;
    end
    th_hit = adc_valid && b_ten && m_prev_ok &&
             ((b_et && d == th) || (b_gt && m_prev <= th && d > th) ||
              (b_lt && m_prev >= th && d < th));
    ex_hit = b_een && ext_trig && !m_ext_prev;
    if (adc_valid) begin
      m_prev    = d;
      m_prev_ok = 1;
    end
    m_ext_prev = ext_trig;
    case (m_mode)
      0: if (b_run) begin m_mode = 1; m_prev_ok = 0; end
      1: begin
        if (!b_run) m_mode = 0;
        else if (th_hit || ex_hit) begin
          m_mode = 2;
          m_src  = (ex_hit ? 2 : 0) + (th_hit ? 1 : 0);
        end
      end
      2: if (trig_ack) begin
        m_mode = 3;
        m_cnt  = (m_cnt + 1) % CNT_MOD;
        m_remaining = (HOLDOFF == 0) ? 1 : HOLDOFF;
      end
      default: begin
        m_remaining--;
        if (m_remaining == 0) m_mode = b_run ? 1 : 0;
      end
    endcase
  endtask

  // Runs n cycles with the currently driven inputs and checks every output after each edge.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      modelStep();
      #1;
      checkOutput("trig_req", int'(trig_req), (m_mode == 2) ? 1 : 0);
      checkOutput("armed",    int'(armed),    (m_mode == 1) ? 1 : 0);
      checkOutput("state_o",  int'(state_o),  m_mode);
      checkOutput("trig_src", int'(trig_src), m_src);
      checkOutput("trig_cnt", int'(trig_cnt), m_cnt);
      @(negedge clk);
    end
  endtask

  task automatic setQuiet();
    rst = 0; adc_valid = 0; adc_data = '0; ext_trig = 0; trig_ack = 0;
  endtask

  task automatic doReset();
    setQuiet();
    rst = 1;
    applyStimulus(2);
    rst = 0;
  endtask

  initial begin
    int v;
    m_mode = 0; m_src = 0; m_cnt = 0; m_prev = 0; m_remaining = 0;
    m_prev_ok = 0; m_ext_prev = 0;
    b_et = 0; b_gt = 0; b_lt = 0; b_run = 0; b_ten = 0; b_een = 0; b_thresh = '0;
    setQuiet();
    @(negedge clk);
    doReset();
    checkOutput("reset_state", int'(state_o), 0);
    checkOutput("reset_cnt", int'(trig_cnt), 0);

    $display("[TB] gt crossing");
    b_gt = 1; b_ten = 1; b_run = 1; b_thresh = 12'h800;
    applyStimulus(1);
    adc_valid = 1; adc_data = 12'h7F0; applyStimulus(1);
    adc_data = 12'h810; applyStimulus(1);
    adc_valid = 0;
    checkOutput("gt_req", int'(trig_req), 1);
    checkOutput("gt_src", int'(trig_src), 1);
    applyStimulus(3);
    trig_ack = 1; applyStimulus(1); trig_ack = 0;
    checkOutput("gt_cnt", int'(trig_cnt), 1);
    applyStimulus(15);
    checkOutput("holdoff_still", int'(state_o), 3);
    applyStimulus(1);
    checkOutput("holdoff_done", int'(state_o), 1);

    $display("[TB] et and lt");
    doReset();
    b_gt = 0; b_et = 1; b_lt = 1; b_thresh = 12'h100;
    applyStimulus(1);
    adc_valid = 1; adc_data = 12'h200; applyStimulus(1);
    adc_data = 12'h100; applyStimulus(1);
    adc_valid = 0;
    checkOutput("et_req", int'(trig_req), 1);
    trig_ack = 1; applyStimulus(1); trig_ack = 0;
    applyStimulus(16);
    b_et = 0;
    adc_valid = 1; adc_data = 12'h200; applyStimulus(1);
    adc_data = 12'h0FF; applyStimulus(1);
    adc_valid = 0;
    checkOutput("lt_req", int'(trig_req), 1);
    trig_ack = 1; applyStimulus(17); trig_ack = 0;

    $display("[TB] external trigger held high and simultaneous hit");
    doReset();
    b_lt = 0; b_gt = 1; b_een = 1; b_thresh = 12'h800;
    applyStimulus(1);
    adc_valid = 1; adc_data = 12'h700; applyStimulus(1);
    adc_data = 12'h900; ext_trig = 1; applyStimulus(1);
    adc_valid = 0;
    checkOutput("both_src", int'(trig_src), 3);
    trig_ack = 1; applyStimulus(1); trig_ack = 0;
    applyStimulus(16);
    ext_trig = 0; applyStimulus(1);
    ext_trig = 1; applyStimulus(10);
    trig_ack = 1; applyStimulus(1); trig_ack = 0;
    applyStimulus(20);
    checkOutput("ext_once_cnt", int'(trig_cnt), 2);

    $display("[TB] run drop handling");
    ext_trig = 0; applyStimulus(1);
    b_run = 0; ext_trig = 1; applyStimulus(1);
    checkOutput("drop_idle", int'(state_o), 0);
    b_run = 1; ext_trig = 0; applyStimulus(1);
    ext_trig = 1; applyStimulus(1);
    b_run = 0; applyStimulus(3);
    trig_ack = 1; applyStimulus(1); trig_ack = 0;
    applyStimulus(16);
    checkOutput("drop_req_idle", int'(state_o), 0);

    $display("[TB] reset during request");
    b_run = 1; ext_trig = 0; applyStimulus(2);
    ext_trig = 1; applyStimulus(1);
    rst = 1; applyStimulus(1); rst = 0;
    checkOutput("rst_req", int'(trig_req), 0);
    checkOutput("rst_cnt", int'(trig_cnt), 0);
    b_run = 0; ext_trig = 0; b_een = 0; applyStimulus(1);
    b_run = 1; adc_valid = 1; adc_data = 12'hFFF; applyStimulus(1);
    adc_data = 12'hFF0; applyStimulus(1);
    checkOutput("post_arm_nofire", int'(trig_req), 0);
    adc_valid = 0;

    $display("[TB] counter wrap");
    doReset();
    b_een = 1; b_ten = 0; b_run = 1;
    applyStimulus(1);
    for (int k = 0; k < CNT_MOD + 1; k++) begin
      ext_trig = 0; applyStimulus(1);
      ext_trig = 1; applyStimulus(1);
      trig_ack = 1; applyStimulus(1); trig_ack = 0;
      applyStimulus(HOLDOFF);
    end
    ext_trig = 0;
    checkOutput("wrap_cnt", int'(trig_cnt), 1);

    $display("[TB] random traffic");
    b_thresh = 12'h400;
    for (int c = 0; c < 3000; c++) begin
      if (c % 50 == 0) b_thresh = 12'($urandom_range(0, 4095));
      rst       = ($urandom_range(0, 299) == 0);
      b_run     = ($urandom_range(0, 39) != 0);
      b_et      = 1'($urandom); b_gt = 1'($urandom); b_lt = 1'($urandom);
      b_ten     = ($urandom_range(0, 5) != 0);
      b_een     = ($urandom_range(0, 2) != 0);
      adc_valid = ($urandom_range(0, 3) != 0);
      v = int'(b_thresh) + $urandom_range(0, 8) - 4;
      if (v < 0) v = 0;
      if (v > 4095) v = 4095;
      adc_data  = 12'(v);
      ext_trig  = ($urandom_range(0, 2) == 0);
      trig_ack  = ($urandom_range(0, 3) == 0);
      applyStimulus(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
